// File: rtl/tone_pkg.sv
// Shared types and constants for the PWM tone capture block: note codes,
// FSM states, bus register offsets and the nominal note-period table.
package tone_pkg;

    typedef enum logic [2:0] {
        NOTE_NONE = 3'd0,
        NOTE_DO   = 3'd1,
        NOTE_RE   = 3'd2,
        NOTE_MI   = 3'd3,
        NOTE_FA   = 3'd4,
        NOTE_UNK  = 3'd7
    } note_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int NUM_NOTES = 4;
    localparam int TOL_SHIFT = 6;

    // Nominal periods in 50 MHz cycles.
    localparam logic [31:0] NOM_DO = 32'd191113;
    localparam logic [31:0] NOM_RE = 32'd170262;
    localparam logic [31:0] NOM_MI = 32'd151686;
    localparam logic [31:0] NOM_FA = 32'd143172;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_PERIOD = 4'h4;
    localparam logic [3:0] REG_HIGH   = 4'h8;
    localparam logic [3:0] REG_RSVD   = 4'hC;

    // Index 0..3 maps DO..FA; shift rescales the table for a slower reference.
    function automatic logic [31:0] nom_cycles(input int idx, input int shift);
        logic [31:0] nom;
        case (idx)
            0:       nom = NOM_DO;
            1:       nom = NOM_RE;
            2:       nom = NOM_MI;
            default: nom = NOM_FA;
        endcase
        return nom >> shift;
    endfunction

endpackage

// File: rtl/tone_classify.sv
// Combinational period-to-note classifier: first table entry (DO..FA) whose
// tolerance band |cnt - NOM| <= NOM>>6 contains the count wins, else unknown.
module tone_classify
    import tone_pkg::*;
#(
    parameter int CNT_W     = 20,
    parameter int NOM_SHIFT = 0
) (
    input  logic [CNT_W-1:0] cnt,
    output logic [2:0]       note
);

    logic [31:0] cnt_ext;

    assign cnt_ext = 32'(cnt);

    function automatic logic in_band(input logic [31:0] c, input logic [31:0] nom);
        logic [31:0] diff;
        diff = (c >= nom) ? (c - nom) : (nom - c);
        return diff <= (nom >> TOL_SHIFT);
    endfunction

    always_comb begin
        // NOTE: default first so every path assigns note and no latch is inferred.
        note = NOTE_UNK;
        // Walk FA..DO so the lowest-index match is the last write and wins.
        for (int k = NUM_NOTES - 1; k >= 0; k--) begin
            if (in_band(cnt_ext, nom_cycles(k, NOM_SHIFT))) begin
                note = 3'(k + 1);
            end
        end
    end

endmodule

// File: rtl/pwm_tone_capture.sv
// Measures period and high time of an asynchronous PWM tone line, classifies
// the period into a note and exposes results on strobed outputs and a read bus.
module pwm_tone_capture
    import tone_pkg::*;
#(
    parameter int CNT_W       = 20,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MIN_PERIOD  = 1000,
    parameter int NOM_SHIFT   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    input  logic             cs,
    input  logic             rd,
    input  logic [3:0]       addr,
    output logic [31:0]      d_out,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [2:0]       note,
    output logic             valid,
    output logic             sample_stb
);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_PERIOD);

    logic [2:0]       sync_q;
    logic             pwm_s;
    logic             rise;
    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] hcnt_inc;
    logic [2:0]       cls_note;
    logic             accept;
    logic             timed_out;
    logic             sticky;
    logic             status_rd;

    // Two synchronizer flops followed by the edge-detect register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its source.
            sync_q <= {sync_q[1:0], pwm_in};
        end
    end

    assign pwm_s = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];

    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign hcnt_inc  = (hcnt == CNT_MAX) ? hcnt : hcnt + CNT_ONE;
    assign accept    = rise && (state != ST_IDLE) && (cnt >= MIN_V);
    assign timed_out = (state != ST_IDLE) && (cnt >= TIMEOUT_V);

    tone_classify #(
        .CNT_W     (CNT_W),
        .NOM_SHIFT (NOM_SHIFT)
    ) u_classify (
        .cnt  (cnt),
        .note (cls_note)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            hcnt       <= '0;
            period     <= '0;
            high_time  <= '0;
            note       <= NOTE_NONE;
            valid      <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            sample_stb <= 1'b0;
            if (state == ST_IDLE) begin
                if (rise) begin
                    state <= ST_ARMED;
                    cnt   <= CNT_ONE;
                    hcnt  <= CNT_ONE;
                end
            end else if (accept) begin
                period     <= cnt;
                high_time  <= hcnt;
                note       <= cls_note;
                valid      <= 1'b1;
                sample_stb <= 1'b1;
                cnt        <= CNT_ONE;
                hcnt       <= CNT_ONE;
                state      <= ST_LOCKED;
            end else if (timed_out && !rise) begin
                // A coincident rising edge (even an ignored one) defers the timeout.
                state     <= ST_IDLE;
                cnt       <= '0;
                hcnt      <= '0;
                period    <= '0;
                high_time <= '0;
                note      <= NOTE_NONE;
                valid     <= 1'b0;
            end else begin
                cnt <= cnt_inc;
                if (pwm_s) begin
                    hcnt <= hcnt_inc;
                end
            end
        end
    end

    assign status_rd = cs && rd && (addr[3:2] == REG_STATUS[3:2]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_out  <= '0;
            sticky <= 1'b0;
        end else begin
            if (cs && rd) begin
                case (addr[3:2])
                    REG_STATUS[3:2]: d_out <= {27'b0, valid, note, sticky};
                    REG_PERIOD[3:2]: d_out <= 32'(period);
                    REG_HIGH[3:2]:   d_out <= 32'(high_time);
                    default:         d_out <= '0;
                endcase
            end
            // Setting beats a coincident clearing read so no sample is lost.
            if (sample_stb) begin
                sticky <= 1'b1;
            end else if (status_rd) begin
                sticky <= 1'b0;
            end
        end
    end

endmodule
